rev_apb_master: RTL and testbench
=================================

REV_APB_MASTER -- requirements
Module: rev_apb_master

Interface
REQ-001 Parameter PADDR_SIZE, default 4, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width; multiple of 8.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles without pready before abort; legal range >= 2.
REQ-004 pclk  input  1  single clock; all flops rise-edge.
REQ-005 prst  input  1  reset, synchronous and active-high; sampled only on the rising edge of pclk.
REQ-006 req_valid  input  1  command valid.
REQ-007 req_ready  output  1  command accepted this cycle when high together with req_valid.
REQ-008 req_addr  input  PADDR_SIZE  target address.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_strb  input  DATA_W/8  write byte strobes.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  pslverr returned, or timeout.
REQ-016 psel, penable, pwrite  output  1 each  APB control.
REQ-017 paddr  output  PADDR_SIZE;  pwdata  output  DATA_W;  pstrb  output  DATA_W/8.
REQ-018 pready, pslverr  input  1 each;  prdata  input  DATA_W.

Function
REQ-019 FSM states: IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-020 req_ready = 1 only in IDLE; it is decoded from the state register.
REQ-021 IDLE: on req_valid & req_ready, latch addr, write, wdata and strb, then go to SETUP.
REQ-022 SETUP lasts exactly 1 cycle: psel=1, penable=0; next state is ACCESS.
REQ-023 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata and pstrb held stable from SETUP through the end of ACCESS.
REQ-024 pstrb = latched strb for writes and all-zero for reads; pwdata = latched wdata for both.
REQ-025 ACCESS with pready=1: rsp_err <= pslverr; rsp_rdata <= prdata if read and !pslverr, else 0; next state is RESP.
REQ-026 Timeout counter:
  - cleared on SETUP entry; increments each ACCESS cycle with pready=0.
  - when it reaches TIMEOUT-1 with pready still 0: rsp_err <= 1, rsp_rdata <= 0, next state is RESP.
  - pready=1 in that same cycle takes priority over the timeout.
REQ-027 RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata and rsp_err held; on rsp_ready go to IDLE; otherwise stay.
REQ-028 Latency: accept at edge k → psel high for cycles k+1 and k+2 → with pready=1 in the first ACCESS cycle, rsp_valid high from cycle k+3.
REQ-029 Minimum command spacing is 4 cycles; req_ready cannot be high in the same cycle as rsp_valid.
REQ-030 Outside SETUP/ACCESS: psel=penable=0, pstrb=0; paddr, pwdata and pwrite keep their last values.
REQ-031 Changes on req_* while not in IDLE are ignored.
REQ-032 pslverr and prdata are sampled only in ACCESS when pready=1.

Reset
REQ-033 While prst=1, or on the first cycle after it:
  - state=IDLE, counter=0.
  - psel, penable, pwrite, pstrb, rsp_valid, rsp_err, rsp_rdata, paddr and pwdata are all 0.
  - req_ready=0 while prst=1.
REQ-034 Reset asserted during SETUP/ACCESS/RESP: the transfer is abandoned, psel drops on the next edge, and no response is ever issued.

Verification
REQ-035 Write: addr=0x2, wdata=0xA5A5_0F0F, strb=0xF, pready=1 immediately → SETUP then ACCESS with pwrite=1 and pstrb=0xF, rsp_valid at k+3 with rsp_err=0 and rsp_rdata=0.
REQ-036 Read with wait states: addr=0x3, pready low for 3 ACCESS cycles, then prdata=0x1234_5678 → pstrb=0 throughout, paddr stable for all 4 ACCESS cycles, rsp_rdata=0x1234_5678.
REQ-037 Slave error: read with pslverr=1, prdata=0xFFFF_FFFF → rsp_err=1, rsp_rdata=0.
REQ-038 Timeout: pready tied 0, TIMEOUT=16 → psel high for 1+16 cycles, then rsp_err=1; a second case with pready=1 exactly on the 16th ACCESS cycle returns rsp_err=0.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err held, req_ready=0, a new req_valid is not accepted; after rsp_ready=1, req_ready=1 the next cycle.
REQ-040 Reset mid-ACCESS: prst=1 during a wait-state read → psel=0 next cycle, rsp_valid never asserts, and the next command completes normally.

Source files
------------

// File: rtl/rev_apb_master.sv
// rtl/rev_apb_master.sv - single-outstanding APB master bridging a request/response command port
// Registered APB outputs, bounded ACCESS wait with timeout abort.
module rev_apb_master #(
    parameter int PADDR_SIZE = 4,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PADDR_SIZE-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [PADDR_SIZE-1:0] paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_W-1:0]     prdata
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q;
    logic [PADDR_SIZE-1:0]   paddr_q;
    logic [DATA_W-1:0]       pwdata_q, rsp_rdata_q;
    logic [DATA_W/8-1:0]     pstrb_q;

    assign req_ready = (state_q == S_IDLE) && !prst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        paddr_q   <= req_addr;
                        pwrite_q  <= req_write;
                        pwdata_q  <= req_wdata;
                        pstrb_q   <= req_write ? req_strb : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A completing pready wins over a timeout in the same cycle.
                    if (pready) begin
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (pready || cnt_q == CNT_LAST) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pstrb_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rev_apb_master.sv
// tb/tb_rev_apb_master.sv - directed self-checking bench for rev_apb_master
module tb_rev_apb_master;
    logic        pclk = 1'b0;
    logic        prst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int checks   = 0;
    int failures = 0;

    rev_apb_master #(.PADDR_SIZE(4), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .prst(prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Presents one command in IDLE; returns with the DUT in SETUP.
    task automatic issue(input logic [3:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        check("issue_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        prst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        req_valid = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_psel", psel, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", paddr, 4'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pstrb", pstrb, 4'h0);
        req_valid = 1'b0;
        prst = 1'b0;
        tick();
        check("post_rst_psel", psel, 1'b0);
        check("post_rst_req_ready", req_ready, 1'b1);

        // Write with immediate pready, then 5 cycles of response backpressure
        pready = 1'b1;
        issue(4'h2, 1'b1, 32'hA5A5_0F0F, 4'hF);
        check("wr_setup_psel", psel, 1'b1);
        check("wr_setup_penable", penable, 1'b0);
        check("wr_setup_pwrite", pwrite, 1'b1);
        check("wr_setup_pstrb", pstrb, 4'hF);
        check("wr_setup_paddr", paddr, 4'h2);
        check("wr_req_ready_busy", req_ready, 1'b0);
        tick();
        check("wr_access_penable", penable, 1'b1);
        check("wr_access_pwdata", pwdata, 32'hA5A5_0F0F);
        check("wr_access_pstrb", pstrb, 4'hF);
        tick();
        check("wr_rsp_valid", rsp_valid, 1'b1);
        check("wr_rsp_err", rsp_err, 1'b0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_resp_psel", psel, 1'b0);
        check("wr_resp_pstrb", pstrb, 4'h0);
        pready = 1'b0;
        req_valid = 1'b1; req_addr = 4'h7; req_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_rdata", rsp_rdata, 32'h0);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_psel", psel, 1'b0);
        end
        req_valid = 1'b0;
        consume();
        check("bp_release_rsp_valid", rsp_valid, 1'b0);
        check("bp_release_req_ready", req_ready, 1'b1);
        check("bp_paddr_kept", paddr, 4'h2);

        // Read with three wait states
        pready = 1'b0;
        issue(4'h3, 1'b0, 32'h0BAD_BEEF, 4'hF);
        check("rd_setup_pstrb", pstrb, 4'h0);
        check("rd_setup_pwrite", pwrite, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_wait_paddr", paddr, 4'h3);
            check("rd_wait_pstrb", pstrb, 4'h0);
            check("rd_wait_penable", penable, 1'b1);
            check("rd_wait_rsp_valid", rsp_valid, 1'b0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
            tick();
        end
        pready = 1'b0; prdata = 32'hDEAD_0000;
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", rsp_err, 1'b0);
        tick();
        check("rd_rdata_held", rsp_rdata, 32'h1234_5678);
        consume();

        // Slave error on a read
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
        issue(4'h1, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        pready = 1'b0; pslverr = 1'b0;
        check("err_rsp_valid", rsp_valid, 1'b1);
        check("err_rsp_err", rsp_err, 1'b1);
        check("err_rsp_rdata", rsp_rdata, 32'h0);
        consume();

        // Timeout with pready held low
        prdata = 32'h5555_AAAA;
        issue(4'h4, 1'b0, 32'h0, 4'h0);
        n = 0;
        while (psel && n < 40) begin
            n++;
            tick();
        end
        check("to_psel_cycles", n, 17);
        check("to_rsp_valid", rsp_valid, 1'b1);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        consume();

        // pready on the final ACCESS cycle beats the timeout
        issue(4'h5, 1'b0, 32'h0, 4'h0);
        tick();
        repeat (15) tick();
        check("to_edge_still_access", penable, 1'b1);
        pready = 1'b1; prdata = 32'hCAFE_F00D;
        tick();
        pready = 1'b0;
        check("to_edge_rsp_valid", rsp_valid, 1'b1);
        check("to_edge_rsp_err", rsp_err, 1'b0);
        check("to_edge_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        consume();

        // Reset during a wait-state ACCESS
        issue(4'h6, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        check("mid_rst_in_access", penable, 1'b1);
        prst = 1'b1;
        tick();
        check("mid_rst_psel", psel, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b0);
        prst = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        issue(4'h9, 1'b1, 32'h0000_00FF, 4'h1);
        check("after_rst_pstrb", pstrb, 4'h1);
        tick();
        tick();
        check("after_rst_rsp_valid", rsp_valid, 1'b1);
        check("after_rst_rsp_err", rsp_err, 1'b0);
        consume();
        check("after_rst_idle", req_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
